down_timer: RTL and testbench

Programmable down-counting timer. Software or upstream logic loads a count value and starts the timer. It decrements on enabled cycles and emits a one-cycle borrow pulse at terminal count. It is the count-down complement of the team's up-counter/carry block: one-shot or auto-reload periods, feeding interval ticks to downstream control logic.

---
 rtl/down_timer.sv | 70 +++++++
 tb/tb_down_timer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: programmable down-counting timer with one-cycle borrow at terminal count
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   load         strobe, captures load_value into reload register and count
//   load_value   value to capture on load
//   start        strobe, begins a count from the reload register (ignored in RUN)
//   en           count enable; a running timer holds while low
//   auto_reload  1 = periodic, 0 = one-shot; sampled at terminal count
//   count        current counter value
//   borrow       one-cycle pulse per consumed terminal count
//   busy         high while running
//   done         high while a one-shot has expired
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             borrow,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] reload_reg, reload_n, count_n;
    logic borrow_n;
    logic term;
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            borrow     <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            borrow     <= borrow_n;
        end
    end
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        borrow_n = 1'b0;
        term     = count == '0;
        if (load) begin
            reload_n = load_value;
            count_n  = load_value;
            state_n  = IDLE;
        end else if (start && state != RUN) begin
            // a zero reload is a zero-length timer: expire immediately with a borrow
            count_n  = reload_reg;
            state_n  = reload_reg != '0 ? RUN : DONE;
            borrow_n = reload_reg == '0;
        end else if (state == RUN && en) begin
            borrow_n = term;
            count_n  = !term ? count - 1'b1 : (auto_reload ? reload_reg : count);
            state_n  = (term && !auto_reload) ? DONE : RUN;
        end
    end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed self-checking bench for down_timer
module tb_down_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] count;
    logic       borrow, busy, done;
    int passed = 0;
    int total = 0;

    down_timer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .en(en), .auto_reload(auto_reload),
        .count(count), .borrow(borrow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_value = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all(input string name, input logic [7:0] c, input logic b, input logic bz, input logic d);
        total++;
        if ({count, borrow, busy, done} !== {c, b, bz, d})
            $display("FAIL %s: count=%0d borrow=%0b busy=%0b done=%0b, expected count=%0d borrow=%0b busy=%0b done=%0b",
                     name, count, borrow, busy, done, c, b, bz, d);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load = 1'b1;
        load_value = 8'd9;
        start = 1'b1;
        tick();
        tick();
        check_all("reset_with_load_start", 8'd0, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        tick();
        check_all("reset_idle", 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_one_shot;
        auto_reload = 1'b0;
        en = 1'b0;
        do_load(8'd3);
        check_all("os_load", 8'd3, 1'b0, 1'b0, 1'b0);
        do_start();
        check_all("os_start", 8'd3, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        tick(); check_all("os_c2", 8'd2, 1'b0, 1'b1, 1'b0);
        tick(); check_all("os_c1", 8'd1, 1'b0, 1'b1, 1'b0);
        tick(); check_all("os_c0", 8'd0, 1'b0, 1'b1, 1'b0);
        tick(); check_all("os_terminal", 8'd0, 1'b1, 1'b0, 1'b1);
        tick(); check_all("os_done_hold", 8'd0, 1'b0, 1'b0, 1'b1);
        tick(); check_all("os_done_hold2", 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_restart_from_done;
        // reload_reg is still 3 from the one-shot
        en = 1'b0;
        do_start();
        check_all("restart_done", 8'd3, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        tick(); check_all("restart_dec", 8'd2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_periodic;
        logic       en_v[9]   = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
        logic [7:0] cnt_v[9]  = '{1, 0, 0, 2, 1, 1, 0, 2, 2};
        logic       brw_v[9]  = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        en = 1'b0;
        auto_reload = 1'b1;
        do_load(8'd2);
        do_start();
        check_all("per_start", 8'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            en = en_v[i];
            tick();
            check_all($sformatf("per_step%0d", i), cnt_v[i], brw_v[i], 1'b1, 1'b0);
        end
    endtask

    task automatic test_abort;
        // running periodic at count 2
        en = 1'b1;
        tick();
        check_all("abort_pre", 8'd1, 1'b0, 1'b1, 1'b0);
        load = 1'b1;
        load_value = 8'd5;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        check_all("abort_load_wins", 8'd5, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("abort_idle_hold", 8'd5, 1'b0, 1'b0, 1'b0);
        do_start();
        check_all("abort_restart", 8'd5, 1'b0, 1'b1, 1'b0);
        tick(); check_all("run_dec", 8'd4, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_all("start_in_run_ignored", 8'd3, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run;
        en = 1'b1;
        auto_reload = 1'b0;
        do_load(8'd7);
        do_start();
        tick();
        tick();
        check_all("mid_run_count5", 8'd5, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all("mid_run_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        // reload register cleared by reset: start is now a zero-length timer
        do_start();
        check_all("reset_clears_reload", 8'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("reset_reload_after", 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_zero_load;
        en = 1'b0;
        do_load(8'd0);
        check_all("zero_load", 8'd0, 1'b0, 1'b0, 1'b0);
        do_start();
        check_all("zero_start", 8'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check_all("zero_after", 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_period;
        int borrows = 0;
        en = 1'b0;
        auto_reload = 1'b1;
        do_load(8'hFF);
        do_start();
        check_all("full_start", 8'hFF, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        for (int i = 1; i <= 512; i++) begin
            tick();
            if (borrow) borrows++;
            if (i % 64 == 0 || i % 256 == 255 || i % 256 == 1)
                check_all($sformatf("full_step%0d", i), 8'(255 - (i % 256)), i % 256 == 0, 1'b1, 1'b0);
        end
        total++;
        if (borrows !== 2) $display("FAIL full_borrow_count: got %0d expected 2", borrows);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_restart_from_done();
        test_periodic();
        test_abort();
        test_reset_mid_run();
        test_zero_load();
        test_full_period();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
